shift_panel: RTL and testbench

- Parametrised front-panel shift-register block for board bring-up.
- Conditions raw switch and button inputs internally: synchroniser, debounce and edge detect per input.
- Drives a WIDTH-bit shift register with serial shift and parallel preset load.
- Shows a pageable LED_W-bit window of the register on LEDs; pages are cycled by a button.

---
 rtl/shift_panel.sv | 124 ++++++++++++
 tb/tb_shift_panel.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_panel.sv
// Front-panel shift register: conditioned switch/button inputs drive a WIDTH-bit
// shift register with a pageable LED window. Define SHIFT_PANEL_DIR_EN to add dir_raw (right shift).
module shift_panel #(
    parameter int               WIDTH    = 8,
    parameter int               LED_W    = 4,
    parameter int               DEBOUNCE = 10,
    parameter logic [WIDTH-1:0] PRESET   = WIDTH'(8'hA5),
    localparam int              PAGES    = WIDTH / LED_W,
    localparam int              PW       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in_raw,
    input  logic             shift_raw,
    input  logic             load_raw,
    input  logic             page_raw,
`ifdef SHIFT_PANEL_DIR_EN
    input  logic             dir_raw,
`endif
    output logic [LED_W-1:0] led,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic [PW-1:0]    page
);

    localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int SER = 0;
    localparam int SHF = 1;
    localparam int LD  = 2;
    localparam int PG  = 3;
`ifdef SHIFT_PANEL_DIR_EN
    localparam int DIR = 4;
    localparam int NIN = 5;
`else
    localparam int NIN = 4;
`endif

    logic [NIN-1:0]         rawVec;
    logic [NIN-1:0]         sync1_q, sync2_q;
    logic [NIN-1:0]         cond_q, cond_d;
    logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
    logic                   shiftPos_q, shiftPos_d;
    logic                   loadNeg_q, loadNeg_d;
    logic                   pagePos_q, pagePos_d;
    logic [WIDTH-1:0]       sr_q, sr_d;
    logic [PW-1:0]          page_q, page_d;
    logic                   shiftRight;

    assign rawVec[SER] = serial_in_raw;
    assign rawVec[SHF] = shift_raw;
    assign rawVec[LD]  = load_raw;
    assign rawVec[PG]  = page_raw;
`ifdef SHIFT_PANEL_DIR_EN
    assign rawVec[DIR] = dir_raw;
    assign shiftRight  = cond_q[DIR];
`else
    assign shiftRight  = 1'b0;
`endif

    // A conditioned level flips only after its synchronised input has disagreed for DEBOUNCE edges.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sync2_q[i] != cond_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                    cond_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        shiftPos_d = cond_d[SHF] & ~cond_q[SHF];
        loadNeg_d  = ~cond_d[LD] & cond_q[LD];
        pagePos_d  = cond_d[PG] & ~cond_q[PG];
    end

    always_comb begin
        sr_d   = sr_q;
        page_d = page_q;
        if (loadNeg_q) begin
            sr_d = PRESET;
        end else if (shiftPos_q) begin
            if (shiftRight) begin
                sr_d = {cond_q[SER], sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], cond_q[SER]};
            end
        end
        if (pagePos_q) begin
            page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cond_q     <= '0;
            cnt_q      <= '0;
            shiftPos_q <= 1'b0;
            loadNeg_q  <= 1'b0;
            pagePos_q  <= 1'b0;
            sr_q       <= '0;
            page_q     <= '0;
        end else begin
            sync1_q    <= rawVec;
            sync2_q    <= sync1_q;
            cond_q     <= cond_d;
            cnt_q      <= cnt_d;
            shiftPos_q <= shiftPos_d;
            loadNeg_q  <= loadNeg_d;
            pagePos_q  <= pagePos_d;
            sr_q       <= sr_d;
            page_q     <= page_d;
        end
    end

    assign led          = sr_q[int'(page_q) * LED_W +: LED_W];
    assign parallel_out = sr_q;
    assign serial_out   = shiftRight ? sr_q[0] : sr_q[WIDTH-1];
    assign page         = page_q;

endmodule

// File: tb/tb_shift_panel.sv
// Randomised self-checking bench for shift_panel against a history-window reference model.
// Build with SHIFT_PANEL_DIR_EN to also exercise right shifts.
module tb_shift_panel;

    localparam int         WIDTH    = 8;
    localparam int         LED_W    = 4;
    localparam int         DEBOUNCE = 4;
    localparam logic [7:0] PRESET   = 8'hA5;
    localparam int         PAGES    = WIDTH / LED_W;
    localparam int         HLEN     = DEBOUNCE + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       serRaw = 1'b0, shiftRaw = 1'b0, loadRaw = 1'b0, pageRaw = 1'b0, dirRaw = 1'b0;
    logic [3:0] led;
    logic [7:0] parallelOut;
    logic       serialOut;
    logic [0:0] page;

    int checks = 0;
    int errors = 0;

    // Reference model: raw sample history per input (bit k = sample k edges ago).
    logic [HLEN-1:0] hist [5];
    logic [4:0]      mCond;
    logic            mShiftPulse, mLoadPulse, mPagePulse;
    logic [7:0]      mSr;
    int              mPage;

    shift_panel #(
        .WIDTH(WIDTH), .LED_W(LED_W), .DEBOUNCE(DEBOUNCE), .PRESET(PRESET)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .serial_in_raw(serRaw),
        .shift_raw(shiftRaw),
        .load_raw(loadRaw),
        .page_raw(pageRaw),
`ifdef SHIFT_PANEL_DIR_EN
        .dir_raw(dirRaw),
`endif
        .led(led),
        .parallel_out(parallelOut),
        .serial_out(serialOut),
        .page(page)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 5; i++) hist[i] = '0;
        mCond       = '0;
        mShiftPulse = 1'b0;
        mLoadPulse  = 1'b0;
        mPagePulse  = 1'b0;
        mSr         = '0;
        mPage       = 0;
    endtask

    // One rising edge: act on pulses seen before the edge, then update conditioned levels.
    task automatic modelStep();
        logic [4:0] rawNow;
        logic       steady;
        if (mLoadPulse) begin
            mSr = PRESET;
        end else if (mShiftPulse) begin
            if (mCond[4]) mSr = (mSr >> 1) | (8'(mCond[0]) << 7);
            else          mSr = 8'((int'(mSr) * 2 + int'(mCond[0])) % 256);
        end
        if (mPagePulse) mPage = (mPage + 1) % PAGES;
        rawNow      = {dirRaw, pageRaw, loadRaw, shiftRaw, serRaw};
        mShiftPulse = 1'b0;
        mLoadPulse  = 1'b0;
        mPagePulse  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hist[i] = {hist[i][HLEN-2:0], rawNow[i]};
            steady  = 1'b1;
            for (int k = 2; k < HLEN; k++) begin
                if (hist[i][k] == mCond[i]) steady = 1'b0;
            end
            if (steady) begin
                mCond[i] = ~mCond[i];
                if (i == 1 && mCond[i])  mShiftPulse = 1'b1;
                if (i == 2 && !mCond[i]) mLoadPulse  = 1'b1;
                if (i == 3 && mCond[i])  mPagePulse  = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("parallel_out", 32'(parallelOut), 32'(mSr));
        checkOutput("led", 32'(led), 32'((mSr >> (mPage * LED_W)) & 8'h0F));
        checkOutput("serial_out", 32'(serialOut), 32'(mCond[4] ? mSr[0] : mSr[7]));
        checkOutput("page", 32'(page), 32'(mPage));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) modelStep();
        @(negedge clk);
        compareAll();
    endtask

    // Called at a falling edge: drive the raw inputs and hold them for a number of cycles.
    task automatic applyStimulus(input logic ser, input logic sh, input logic ld, input logic pg, input int cycles);
        serRaw   = ser;
        shiftRaw = sh;
        loadRaw  = ld;
        pageRaw  = pg;
        repeat (cycles) tick();
    endtask

    initial begin
        modelReset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("idle_parallel", 32'(parallelOut), 32'h0);

        applyStimulus(0, 0, 1, 0, 10);
        checkOutput("load_press_no_change", 32'(parallelOut), 32'h0);
        applyStimulus(0, 0, 0, 0, 10);
        checkOutput("load_parallel", 32'(parallelOut), 32'hA5);
        checkOutput("load_led", 32'(led), 32'h5);
        checkOutput("load_serial", 32'(serialOut), 32'h1);

        applyStimulus(1, 0, 0, 0, 10);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("shift1_parallel", 32'(parallelOut), 32'h4B);
        checkOutput("shift1_serial", 32'(serialOut), 32'h0);
        applyStimulus(1, 0, 0, 0, 8);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("shift2_parallel", 32'(parallelOut), 32'h97);
        checkOutput("shift2_serial", 32'(serialOut), 32'h1);
        applyStimulus(1, 0, 0, 0, 8);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("shift3_parallel", 32'(parallelOut), 32'h2F);
        checkOutput("shift3_serial", 32'(serialOut), 32'h0);
        applyStimulus(1, 0, 0, 0, 8);

        applyStimulus(1, 0, 1, 0, 10);
        applyStimulus(1, 0, 0, 0, 10);
        applyStimulus(1, 1, 0, 0, 3);
        applyStimulus(1, 0, 0, 0, 10);
        checkOutput("short_pulse_ignored", 32'(parallelOut), 32'hA5);

        applyStimulus(1, 0, 0, 1, 8);
        checkOutput("page1_page", 32'(page), 32'h1);
        checkOutput("page1_led", 32'(led), 32'hA);
        applyStimulus(1, 0, 0, 0, 8);
        applyStimulus(1, 0, 0, 1, 8);
        checkOutput("page_wrap_page", 32'(page), 32'h0);
        checkOutput("page_wrap_led", 32'(led), 32'h5);
        applyStimulus(1, 0, 0, 0, 8);

        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("pre_collide_parallel", 32'(parallelOut), 32'h4B);
        applyStimulus(1, 0, 0, 0, 8);
        applyStimulus(1, 0, 1, 0, 10);
        applyStimulus(1, 1, 0, 0, 10);
        checkOutput("collide_load_wins", 32'(parallelOut), 32'hA5);
        applyStimulus(1, 0, 0, 0, 10);

`ifdef SHIFT_PANEL_DIR_EN
        dirRaw = 1'b1;
        applyStimulus(1, 0, 0, 0, 10);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("dir_right_parallel", 32'(parallelOut), 32'hD2);
        checkOutput("dir_right_serial", 32'(serialOut), 32'h0);
        applyStimulus(1, 0, 0, 0, 8);
        dirRaw = 1'b0;
        applyStimulus(1, 0, 0, 0, 10);
`endif

        // Async reset mid-cycle while a load press is still being debounced.
        applyStimulus(0, 0, 1, 0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_parallel", 32'(parallelOut), 32'h0);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_page", 32'(page), 32'h0);
        checkOutput("reset_serial", 32'(serialOut), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("post_reset_idle", 32'(parallelOut), 32'h0);

        for (int seg = 0; seg < 300; seg++) begin
`ifdef SHIFT_PANEL_DIR_EN
            if ($urandom_range(0, 7) == 0) dirRaw = $urandom_range(0, 1) == 1;
`endif
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          int'($urandom_range(1, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
